// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-source round-robin packet arbiter that drives the
// select of a shared WIDTH-bit 2:1 data mux. A grant is held from the first
// beat through the beat flagged last, then priority rotates so that two
// continuously requesting sources alternate packets.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i0_valid,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_last,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_last,
    output logic             i1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_owner_q;
    logic       last_owner_d;
    logic       sel_q;
    logic       sel_d;

    logic       own0;
    logic       own1;
    logic       i0_eop;
    logic       i1_eop;

    assign own0   = (state_q == ST_OWN0);
    assign own1   = (state_q == ST_OWN1);

    // End-of-packet handshakes; only meaningful while the matching grant is held.
    assign i0_eop = i0_valid & out_ready & i0_last;
    assign i1_eop = i1_valid & out_ready & i1_last;

    // Grant arbitration and release: ties go to the source that did not finish
    // the previous packet, and a waiting source takes over with no idle cycle.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (i0_valid && i1_valid) begin
                    state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
                end else if (i0_valid) begin
                    state_d = ST_OWN0;
                end else if (i1_valid) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (i0_eop) begin
                    last_owner_d = 1'b0;
                    state_d      = i1_valid ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (i1_eop) begin
                    last_owner_d = 1'b1;
                    state_d      = i0_valid ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The select follows the granted source and holds its value through IDLE,
    // so it only moves on edges where the grant itself moves.
    always_comb begin
        sel_d = sel_q;
        if (state_d == ST_OWN0) begin
            sel_d = 1'b0;
        end else if (state_d == ST_OWN1) begin
            sel_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            sel_q        <= sel_d;
        end
    end

    // Zero-latency pass-through of the granted source; the non-granted source
    // never sees ready, and nothing is presented while no grant is held.
    assign out_data  = sel_q ? i1_data : i0_data;
    assign out_valid = (own0 & i0_valid) | (own1 & i1_valid);
    assign out_last  = (own0 & i0_last) | (own1 & i1_last);
    assign i0_ready  = own0 & out_ready;
    assign i1_ready  = own1 & out_ready;
    assign sel       = sel_q;
    assign busy      = own0 | own1;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios followed by a
// randomized phase, all compared every cycle against a packet-ownership model.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             v0, l0, v1, l1, ordy;
    logic [WIDTH-1:0] d0, d1;
    logic             i0_ready, i1_ready, out_valid, out_last, sel, busy;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;
    bit chk_en;

    // Model: who owns the sink (-1 = nobody), who finished last, select value.
    int   m_owner;
    int   m_last;
    logic m_sel;

    logic [7:0] beat_log[$];

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_valid (v0),
        .i0_data  (d0),
        .i0_last  (l0),
        .i0_ready (i0_ready),
        .i1_valid (v1),
        .i1_data  (d1),
        .i1_last  (l1),
        .i1_ready (i1_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(ordy),
        .sel      (sel),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected combinational outputs from the current ownership and inputs.
    task automatic check_outputs();
        logic       ev, el;
        logic [7:0] ed;
        ev = (m_owner == 0) ? v0 : (m_owner == 1) ? v1 : 1'b0;
        el = (m_owner == 0) ? l0 : (m_owner == 1) ? l1 : 1'b0;
        ed = m_sel ? d1 : d0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("out_last", {31'd0, out_last}, {31'd0, el});
        chk("out_data", {24'd0, out_data}, {24'd0, ed});
        chk("i0_ready", {31'd0, i0_ready}, {31'd0, (m_owner == 0) && ordy});
        chk("i1_ready", {31'd0, i1_ready}, {31'd0, (m_owner == 1) && ordy});
        chk("sel", {31'd0, sel}, {31'd0, m_sel});
        chk("busy", {31'd0, busy}, {31'd0, m_owner >= 0});
    endtask

    // Ownership rules applied at a clock edge with the inputs present then.
    task automatic model_edge();
        int g;
        bit done;
        bit other_v;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 1;
            m_sel   = 1'b0;
        end else if (m_owner < 0) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
            else           g = -1;
            if (g >= 0) begin
                m_owner = g;
                m_sel   = (g == 1);
            end
        end else begin
            done    = (m_owner == 0) ? (v0 && ordy && l0) : (v1 && ordy && l1);
            other_v = (m_owner == 0) ? v1 : v0;
            if (done) begin
                m_last = m_owner;
                if (other_v) begin
                    m_owner = 1 - m_owner;
                    m_sel   = (m_owner == 1);
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock: check, log any accepted beat, advance the model.
    task automatic cycle();
        logic       acc, s, lst;
        logic [7:0] dat;
        #1;
        if (chk_en) check_outputs();
        acc = out_valid && ordy;
        dat = out_data;
        s   = sel;
        lst = out_last;
        @(posedge clk);
        if (acc === 1'b1 && rst_n) begin
            beat_log.push_back(dat);
            $display("beat src=%0d data=%02h last=%0b", s, dat, lst);
        end
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_rr [8];
        logic [7:0] exp_bp [2];
        logic [7:0] exp_gap [3];
        int         idx0, idx1;
        bit         acc0, acc1;

        exp_rr  = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
        exp_bp  = '{8'hC0, 8'hC1};
        exp_gap = '{8'hD0, 8'hD1, 8'hE0};

        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; l0 = 1'b0; l1 = 1'b0;
        d0 = 8'h00; d1 = 8'h00; ordy = 1'b0;
        m_owner = -1; m_last = 1; m_sel = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);

        // Reset held 3 cycles with both sources requesting.
        cycle();
        chk_en = 1'b1;
        cycle();
        cycle();
        #1;
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {30'd0, i0_ready, i1_ready}, 32'd0);
        rst_n = 1'b1;
        cycle();
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        chk("post_rst_sel", {31'd0, sel}, 32'd0);
        v1 = 1'b0; ordy = 1'b1; l0 = 1'b1;
        cycle();
        v0 = 1'b0; l0 = 1'b0;
        cycle();

        // Single source, 3-beat packet on i1.
        beat_log.delete();
        v1 = 1'b1; d1 = 8'h11; l1 = 1'b0;
        cycle();
        #1;
        chk("s1_sel", {31'd0, sel}, 32'd1);
        chk("s1_i0_ready", {31'd0, i0_ready}, 32'd0);
        cycle();
        d1 = 8'h22;
        cycle();
        d1 = 8'h33; l1 = 1'b1;
        #1;
        chk("s1_last", {31'd0, out_last}, 32'd1);
        cycle();
        v1 = 1'b0; l1 = 1'b0;
        #1;
        chk("s1_idle", {31'd0, busy}, 32'd0);
        chk("s1_count", beat_log.size(), 32'd3);
        if (beat_log.size() == 3) chk("s1_beat2", {24'd0, beat_log[2]}, 32'h33);
        cycle();

        // Contention: both sources stream 2-beat packets.
        beat_log.delete();
        idx0 = 0; idx1 = 0;
        v0 = 1'b1; v1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            d0 = 8'hA0 + 8'(idx0); l0 = (idx0 == 1);
            d1 = 8'hB0 + 8'(idx1); l1 = (idx1 == 1);
            acc0 = (m_owner == 0) && ordy;
            acc1 = (m_owner == 1) && ordy;
            cycle();
            if (acc0) idx0 ^= 1;
            if (acc1) idx1 ^= 1;
        end
        chk("rr_count", beat_log.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < beat_log.size()) chk("rr_order", {24'd0, beat_log[k]}, {24'd0, exp_rr[k]});
        end
        v1 = 1'b0; l1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            d0 = 8'hA0 + 8'(idx0); l0 = (idx0 == 1);
            acc0 = (m_owner == 0) && ordy;
            cycle();
            if (acc0) idx0 ^= 1;
        end
        v0 = 1'b0; l0 = 1'b0;
        cycle();

        // Backpressure on an i0 packet.
        beat_log.delete();
        v0 = 1'b1; d0 = 8'hC0; l0 = 1'b0; ordy = 1'b1;
        cycle();
        #1;
        chk("bp_rdy1", {31'd0, i0_ready}, 32'd1);
        cycle();
        d0 = 8'hC1; l0 = 1'b1; ordy = 1'b0;
        #1;
        chk("bp_rdy0", {31'd0, i0_ready}, 32'd0);
        chk("bp_sel", {31'd0, sel}, 32'd0);
        cycle();
        cycle();
        ordy = 1'b1;
        cycle();
        v0 = 1'b0; l0 = 1'b0;
        chk("bp_count", beat_log.size(), 32'd2);
        for (int k = 0; k < 2; k++) begin
            if (k < beat_log.size()) chk("bp_beat", {24'd0, beat_log[k]}, {24'd0, exp_bp[k]});
        end

        // Mid-packet valid gap on i0 while i1 waits.
        beat_log.delete();
        v0 = 1'b1; d0 = 8'hD0; l0 = 1'b0;
        cycle();
        v1 = 1'b1; d1 = 8'hE0; l1 = 1'b1;
        cycle();
        v0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_sel", {31'd0, sel}, 32'd0);
            chk("gap_i1_ready", {31'd0, i1_ready}, 32'd0);
            chk("gap_out_valid", {31'd0, out_valid}, 32'd0);
            cycle();
        end
        v0 = 1'b1; d0 = 8'hD1; l0 = 1'b1;
        cycle();
        v0 = 1'b0; l0 = 1'b0;
        #1;
        chk("gap_handover_sel", {31'd0, sel}, 32'd1);
        cycle();
        v1 = 1'b0; l1 = 1'b0;
        cycle();
        chk("gap_count", beat_log.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < beat_log.size()) chk("gap_beat", {24'd0, beat_log[k]}, {24'd0, exp_gap[k]});
        end

        // Reset during beat 2 of an i1 packet, then a fresh tie.
        v1 = 1'b1; d1 = 8'hF0; l1 = 1'b0; d0 = 8'h5A;
        cycle();
        cycle();
        d1 = 8'hF1; rst_n = 1'b0;
        cycle();
        #1;
        chk("mrst_sel", {31'd0, sel}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_rdy", {30'd0, i0_ready, i1_ready}, 32'd0);
        chk("mrst_out_data", {24'd0, out_data}, 32'h5A);
        rst_n = 1'b1; v0 = 1'b1;
        cycle();
        #1;
        chk("mrst_tie_busy", {31'd0, busy}, 32'd1);
        chk("mrst_tie_sel", {31'd0, sel}, 32'd0);
        l0 = 1'b1; v1 = 1'b0;
        cycle();
        v0 = 1'b0; l0 = 1'b0;
        cycle();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            v0    = ($urandom_range(0, 3) != 0);
            v1    = ($urandom_range(0, 3) != 0);
            l0    = ($urandom_range(0, 2) == 0);
            l1    = ($urandom_range(0, 2) == 0);
            d0    = 8'($urandom);
            d1    = 8'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
